sc_datamem_io: RTL and testbench
================================

// Module: sc_datamem_io
// PURPOSE
//  Parametrised data-memory plus memory-mapped I/O block for the sc_computer datapath.
//  - Single-port word RAM with byte enables.
//  - N_OUT registered output ports, N_IN synchronised input ports.
//  - One address bit selects RAM versus I/O space.
//  - Single clock; registered read with a one-cycle valid strobe, for pipelined cores.
// PARAMETERS
//  MEM_AW  5  RAM word-address width; RAM holds 2**MEM_AW 32-bit words
//  N_OUT   3  number of output ports (1..16)
//  N_IN    2  number of input ports (1..15)
//  IO_BIT     = MEM_AW+2 (localparam); addr bit that selects I/O space
// PORTS
//  clock     in   1          system clock; all state changes on the rising edge
//  resetn    in   1          synchronous, active-low reset
//  addr      in   32         byte address; addr[1:0] ignored
//  datain    in   32         store data
//  we        in   1          store request
//  be        in   4          byte enables for a store; be[0] = bits 7:0
//  re        in   1          load request
//  dataout   out  32         load data, registered
//  rvalid    out  1          one-cycle pulse, dataout valid
//  in_port   in   N_IN*32    asynchronous inputs, port k = [32k+31:32k]
//  out_port  out  N_OUT*32   output registers, port k = [32k+31:32k]
//  irq       out  1          input-change interrupt (only with macro, see CONFIGURATION)
// BEHAVIOUR
//  - Address decode
//    - addr[IO_BIT]=0: RAM word addr[MEM_AW+1:2].
//    - addr[IO_BIT]=1: I/O offset off = addr[6:2].
//  - I/O map
//    - off 0..N_OUT-1: out_port[off], read/write.
//    - off 16..16+N_IN-1: synchronised in_port[off-16], read-only; stores ignored.
//    - off 31: STATUS, when the macro is defined.
//    - Any other offset reads 0 and ignores stores.
//  - Reset (resetn=0 at a rising edge)
//    - dataout, rvalid, out_port, input synchronisers, STATUS and irq all go to 0.
//    - RAM contents are not reset.
//    - A load or store sampled in the same cycle is discarded.
//  - Store (we=1 at edge N)
//    - Only bytes with be[i]=1 are written, to RAM or out_port, at edge N.
//    - New out_port value is visible after edge N.
//    - be=0000 writes nothing.
//  - Load (re=1 at edge N)
//    - dataout holds the addressed word and rvalid=1 after edge N.
//    - rvalid drops after edge N+1 unless re is held.
//    - Back-to-back loads give one result per cycle.
//    - dataout holds its last value while rvalid=0.
//  - Load and store in the same cycle
//    - The load returns the OLD word (read-before-write).
//    - The store completes normally.
//  - Inputs
//    - Each in_port passes through a two-flop synchroniser.
//    - A load of an input offset returns the second stage.
//    - Latency from a pin change to a readable value is 2 edges.
//  - Width rules
//    - The address is not range-checked beyond decode: upper addr bits above IO_BIT are ignored.
//    - RAM index wraps modulo 2**MEM_AW.
// CONFIGURATION
//  SC_DATAMEM_IO_CHANGE_IRQ_EN defined
//  - STATUS at off 31: bit k sets when synchroniser stage 2 of port k differs from stage 3.
//    (Stage 3 is an extra edge-detect register per port.)
//  - STATUS bits are write-1-to-clear, with be[0..3] honoured per byte.
//  - A set event beats a clear on the same edge.
//  - irq = registered |STATUS, asserted one edge after the bit sets.
//  SC_DATAMEM_IO_CHANGE_IRQ_EN not defined
//  - No stage-3 registers and no STATUS; off 31 reads 0.
//  - irq is tied to 0.
// TESTING
//  1. Reset: resetn=0 one edge -> out_port all 0, rvalid=0, dataout=0, irq=0.
//  2. RAM: store 0xDEADBEEF at 0x04, be=1111; then store 0x000000AA at 0x04, be=0001;
//     load 0x04 -> next cycle rvalid=1, dataout=0xDEADBEAA.
//  3. Output port: store 0x12345678 to 0x84 (off 1) -> out_port[63:32]=0x12345678 after that edge;
//     load 0x84 returns it; store to 0xC0 (off 16) leaves everything unchanged.
//  4. Input port: in_port[31:0]=0x55 -> load 0xC0 issued 2 edges later returns 0x55;
//     issued 1 edge later it returns the old value.
//  5. Same cycle: re=1, we=1 to 0x08 (old 0x1, new 0x2) -> dataout=0x1, then a load gives 0x2.
//  6. Macro: toggle in_port[32] -> STATUS bit1=1 and irq=1 within 4 edges;
//     store 0x2 to 0xFC -> STATUS=0 and irq=0 next edge.
//     Without the macro, irq stays 0.

Source files
------------

// File: rtl/sc_datamem_io.sv
// Data memory plus memory-mapped I/O for the sc_computer datapath: byte-enabled word RAM,
// registered output ports, synchronised input ports. Optional change IRQ: SC_DATAMEM_IO_CHANGE_IRQ_EN.
module sc_datamem_io #(
   parameter int MEM_AW = 5,
   parameter int N_OUT  = 3,
   parameter int N_IN   = 2
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [31:0]          addr,
   input  logic [31:0]          datain,
   input  logic                 we,
   input  logic [3:0]           be,
   input  logic                 re,
   output logic [31:0]          dataout,
   output logic                 rvalid,
   input  logic [N_IN*32-1:0]   in_port,
   output logic [N_OUT*32-1:0]  out_port,
   output logic                 irq
);

   localparam int IO_BIT = MEM_AW + 2;
   localparam int DEPTH  = 1 << MEM_AW;

   function automatic logic [31:0] byte_mask(input logic [3:0] be_i);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{be_i[b]}};
      end
      return m;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be_i);
      logic [31:0] m;
      m = byte_mask(be_i);
      return (old_w & ~m) | (new_w & m);
   endfunction

   logic [31:0]          mem [DEPTH];
   logic                 io_sel_s;
   logic [MEM_AW-1:0]    ram_idx_s;
   logic [4:0]           off_s;
   logic [31:0]          rdata_s;
   logic                 unused_s;

   logic [31:0]          dataout_q, dataout_d;
   logic                 rvalid_q, rvalid_d;
   logic [N_OUT*32-1:0]  out_q, out_d;
   logic [N_IN*32-1:0]   sync1_q, sync2_q;

`ifdef SC_DATAMEM_IO_CHANGE_IRQ_EN
   logic [N_IN*32-1:0]   sync3_q;
   logic [N_IN-1:0]      status_q, status_d, chg_s, clr_s;
   logic                 irq_q, irq_d;
   logic [31:0]          clr_word_s;
`endif

   // Address decode; bits above IO_BIT and the byte offset are deliberately ignored.
   always_comb begin
      io_sel_s  = addr[IO_BIT];
      ram_idx_s = addr[MEM_AW+1:2];
      off_s     = addr[6:2];
   end

   assign unused_s = ^{addr[31:IO_BIT+1], addr[1:0]};

   // Read mux: every source is the pre-edge value, giving read-before-write.
   always_comb begin
      rdata_s = 32'd0;
      if (!io_sel_s) begin
         rdata_s = mem[ram_idx_s];
      end else begin
         for (int k = 0; k < N_OUT; k++) begin
            if (off_s == 5'(k)) rdata_s = out_q[32*k +: 32];
         end
         for (int k = 0; k < N_IN; k++) begin
            if (off_s == 5'(16 + k)) rdata_s = sync2_q[32*k +: 32];
         end
`ifdef SC_DATAMEM_IO_CHANGE_IRQ_EN
         if (off_s == 5'd31) rdata_s = {{(32-N_IN){1'b0}}, status_q};
`endif
      end
   end

   // Next-state for load result and output port registers.
   always_comb begin
      rvalid_d  = re;
      dataout_d = re ? rdata_s : dataout_q;
      out_d     = out_q;
      for (int k = 0; k < N_OUT; k++) begin
         if (we && io_sel_s && (off_s == 5'(k))) begin
            out_d[32*k +: 32] = merge_bytes(out_q[32*k +: 32], datain, be);
         end
      end
   end

   // Registered load path, output ports and input synchronisers.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         dataout_q <= 32'd0;
         rvalid_q  <= 1'b0;
         out_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
      end else begin
         dataout_q <= dataout_d;
         rvalid_q  <= rvalid_d;
         out_q     <= out_d;
         sync1_q   <= in_port;
         sync2_q   <= sync1_q;
      end
   end

   // RAM storage is not reset; a store during reset is dropped.
   always_ff @(posedge clock) begin
      if (resetn && we && !io_sel_s) begin
         mem[ram_idx_s] <= merge_bytes(mem[ram_idx_s], datain, be);
      end
   end

`ifdef SC_DATAMEM_IO_CHANGE_IRQ_EN
   // Change detect and write-1-to-clear STATUS; a new event wins over a clear.
   always_comb begin
      clr_word_s = datain & byte_mask(be);
      for (int k = 0; k < N_IN; k++) begin
         chg_s[k] = |(sync2_q[32*k +: 32] ^ sync3_q[32*k +: 32]);
      end
      if (we && io_sel_s && (off_s == 5'd31)) begin
         clr_s = clr_word_s[N_IN-1:0];
      end else begin
         clr_s = '0;
      end
      status_d = (status_q & ~clr_s) | chg_s;
      irq_d    = |status_q;
   end

   // Edge-detect stage, STATUS and interrupt registers.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         sync3_q  <= '0;
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         sync3_q  <= sync2_q;
         status_q <= status_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign dataout  = dataout_q;
   assign rvalid   = rvalid_q;
   assign out_port = out_q;

endmodule

// File: tb/tb_sc_datamem_io.sv
// Directed self-checking bench for sc_datamem_io (default parameters).
module tb_sc_datamem_io;

   logic         clock;
   logic         resetn;
   logic [31:0]  addr;
   logic [31:0]  datain;
   logic         we;
   logic [3:0]   be;
   logic         re;
   logic [31:0]  dataout;
   logic         rvalid;
   logic [63:0]  in_port;
   logic [95:0]  out_port;
   logic         irq;

   int n_checks = 0;
   int n_fail   = 0;

   sc_datamem_io #(.MEM_AW(5), .N_OUT(3), .N_IN(2)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .addr     (addr),
      .datain   (datain),
      .we       (we),
      .be       (be),
      .re       (re),
      .dataout  (dataout),
      .rvalid   (rvalid),
      .in_port  (in_port),
      .out_port (out_port),
      .irq      (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; datain = d; be = b; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic load(input logic [31:0] a);
      addr = a; re = 1'b1;
      step();
      re = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; addr = 32'h80; datain = 32'hFFFF_FFFF; we = 1'b1; be = 4'hF;
      re = 1'b1; in_port = 64'd0;

      // Reset with a store and a load pending: both discarded
      step();
      check_eq("rst_out0", out_port[31:0], 32'd0);
      check_eq("rst_out1", out_port[63:32], 32'd0);
      check_eq("rst_out2", out_port[95:64], 32'd0);
      check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check_eq("rst_dataout", dataout, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      resetn = 1'b1; we = 1'b0; re = 1'b0;
      step();
      check_eq("idle_rvalid", {31'd0, rvalid}, 32'd0);

      // RAM byte-enabled store
      store(32'h04, 32'hDEAD_BEEF, 4'b1111);
      store(32'h04, 32'h0000_00AA, 4'b0001);
      store(32'h04, 32'h1111_1111, 4'b0000);
      load(32'h04);
      check_eq("ram_rvalid", {31'd0, rvalid}, 32'd1);
      check_eq("ram_data", dataout, 32'hDEAD_BEAA);
      step();
      check_eq("ram_rvalid_drop", {31'd0, rvalid}, 32'd0);
      check_eq("ram_data_hold", dataout, 32'hDEAD_BEAA);

      // Output ports
      store(32'h84, 32'h1234_5678, 4'b1111);
      check_eq("out1_write", out_port[63:32], 32'h1234_5678);
      load(32'h84);
      check_eq("out1_read", dataout, 32'h1234_5678);
      store(32'hC0, 32'hFFFF_FFFF, 4'b1111);
      check_eq("ro_out0", out_port[31:0], 32'd0);
      check_eq("ro_out1", out_port[63:32], 32'h1234_5678);
      check_eq("ro_out2", out_port[95:64], 32'd0);
      store(32'h84, 32'hFFFF_FFFF, 4'b0000);
      check_eq("out1_be0", out_port[63:32], 32'h1234_5678);
      store(32'h88, 32'h00AB_CDEF, 4'b0100);
      check_eq("out2_byte", out_port[95:64], 32'h00AB_0000);
      store(32'h94, 32'hFFFF_FFFF, 4'b1111);
      load(32'h94);
      check_eq("unmapped_rd", dataout, 32'd0);
      check_eq("unmapped_ram_intact", out_port[31:0], 32'd0);

      // Input synchroniser latency: one edge is too early, two edges is enough
      in_port[31:0] = 32'h55;
      step();
      addr = 32'hC0; re = 1'b1;
      step();
      check_eq("in0_early", dataout, 32'd0);
      step();
      check_eq("in0_ready", dataout, 32'h55);
      check_eq("in0_b2b_rvalid", {31'd0, rvalid}, 32'd1);
      re = 1'b0;

      // Load and store same cycle: read-before-write
      store(32'h08, 32'h1, 4'b1111);
      addr = 32'h08; datain = 32'h2; be = 4'hF; we = 1'b1; re = 1'b1;
      step();
      we = 1'b0; re = 1'b0;
      check_eq("rbw_old", dataout, 32'h1);
      load(32'h08);
      check_eq("rbw_new", dataout, 32'h2);
      load(32'h108);
      check_eq("upper_addr_ignored", dataout, 32'h2);
      load(32'h04);
      check_eq("ram_w1_intact", dataout, 32'hDEAD_BEAA);

`ifdef SC_DATAMEM_IO_CHANGE_IRQ_EN
      // Clear the event left over from the port-0 change, then toggle port 1
      store(32'hFC, 32'hFFFF_FFFF, 4'b1111);
      step();
      step();
      check_eq("irq_cleared", {31'd0, irq}, 32'd0);
      in_port[32] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (irq !== 1'b1) step();
      end
      check_eq("irq_set", {31'd0, irq}, 32'd1);
      store(32'hFC, 32'h2, 4'b0000);
      load(32'hFC);
      check_eq("status_be0_keeps", dataout, 32'h2);
      store(32'hFC, 32'h2, 4'b0001);
      load(32'hFC);
      check_eq("status_w1c", dataout, 32'h0);
      check_eq("irq_w1c", {31'd0, irq}, 32'd0);
`else
      in_port[32] = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check_eq("irq_tied", {31'd0, irq}, 32'd0);
      load(32'hFC);
      check_eq("status_absent", dataout, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
